// File: rtl/fwd_hazard_pkg.sv
// Shared types for the forwarding / hazard controller: EX operand select
// encodings, the per-stage pipeline record and the "record writes source" test.
package fwd_hazard_pkg;

  localparam logic [1:0] SEL_REG    = 2'b00;
  localparam logic [1:0] SEL_EXOUT  = 2'b01;
  localparam logic [1:0] SEL_MEMOUT = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
  } stage_rec_t;

  localparam int REC_W = $bits(stage_rec_t);

  // r0 is hard-wired zero, so a write to it never produces a forwardable value.
  function automatic logic rec_writes(input logic       valid,
                                      input logic       regwrite,
                                      input logic [4:0] rd,
                                      input logic [4:0] src);
    return valid && regwrite && (rd == src) && (src != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Combinational operand-select lookup: the youngest in-flight producer of src
// wins (EX over MEM); no producer means the register file value is current.
module fwd_sel
  import fwd_hazard_pkg::*;
(
  input  logic [4:0]       src,
  input  logic [REC_W-1:0] ex_rec,
  input  logic [REC_W-1:0] mem_rec,
  output logic [1:0]       sel
);

  stage_rec_t ex_r;
  stage_rec_t mem_r;
  logic       unused_load;

  assign ex_r        = stage_rec_t'(ex_rec);
  assign mem_r       = stage_rec_t'(mem_rec);
  assign unused_load = ex_r.load ^ mem_r.load;

  always_comb begin
    sel = SEL_REG;
    if (rec_writes(ex_r.valid, ex_r.regwrite, ex_r.rd, src)) begin
      sel = SEL_EXOUT;
    end else if (rec_writes(mem_r.valid, mem_r.regwrite, mem_r.rd, src)) begin
      sel = SEL_MEMOUT;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage pipeline. Define
// FWD_HAZARD_FWD_EN to enable EX/MEM forwarding; otherwise hazards stall.
module fwd_hazard_ctrl
  import fwd_hazard_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       id_st_data,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_load,
  input  logic       ex_fail,
  output logic [1:0] ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] MemWrSrc,
  output logic       stall,
  output logic       flush
);

  if (NREG < 2 || NREG > 32) begin : g_nreg_check
    $error("NREG must be within 2..32 to fit 5-bit register indices");
  end

  stage_rec_t ex_q, ex_d;
  stage_rec_t mem_q, mem_d;
  stage_rec_t wb_q, wb_d;
  logic [1:0] alu_a_q, alu_a_d;
  logic [1:0] alu_b_q, alu_b_d;
  logic [1:0] mem_wr_q, mem_wr_d;
  logic [1:0] sel_a, sel_b, sel_st;
  logic       hazard;
  logic       advance;
  logic       unused_wb;

  // WB is tracked for completeness only; the register file is write-before-read.
  assign unused_wb = ^wb_q;

  fwd_sel u_sel_a  (.src(id_rs), .ex_rec(ex_q), .mem_rec(mem_q), .sel(sel_a));
  fwd_sel u_sel_b  (.src(id_rt), .ex_rec(ex_q), .mem_rec(mem_q), .sel(sel_b));
  fwd_sel u_sel_st (.src(id_rt), .ex_rec(ex_q), .mem_rec(mem_q), .sel(sel_st));

  always_comb begin
    hazard = 1'b0;
`ifdef FWD_HAZARD_FWD_EN
    // Only a load in EX is unforwardable: its data is not ready until MEM.
    hazard = ex_q.load && ((id_rs_used && (sel_a  == SEL_EXOUT)) ||
                           (id_rt_used && (sel_b  == SEL_EXOUT)) ||
                           (id_st_data && (sel_st == SEL_EXOUT)));
`else
    hazard = (id_rs_used && (sel_a  != SEL_REG)) ||
             (id_rt_used && (sel_b  != SEL_REG)) ||
             (id_st_data && (sel_st != SEL_REG));
`endif
  end

  assign flush   = ex_fail && !rst;
  assign stall   = id_valid && hazard && !ex_fail && !rst;
  assign advance = id_valid && !stall && !flush;

  always_comb begin
    mem_d    = ex_q;
    wb_d     = mem_q;
    ex_d     = '0;
    alu_a_d  = SEL_REG;
    alu_b_d  = SEL_REG;
    mem_wr_d = SEL_REG;
    if (advance) begin
      ex_d = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, load: id_load};
`ifdef FWD_HAZARD_FWD_EN
      alu_a_d  = id_rs_used ? sel_a  : SEL_REG;
      alu_b_d  = id_rt_used ? sel_b  : SEL_REG;
      mem_wr_d = id_st_data ? sel_st : SEL_REG;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      alu_a_q  <= SEL_REG;
      alu_b_q  <= SEL_REG;
      mem_wr_q <= SEL_REG;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      mem_wr_q <= mem_wr_d;
    end
  end

  assign ALUsrcA  = alu_a_q;
  assign ALUsrcB  = alu_b_q;
  assign MemWrSrc = mem_wr_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter NREG, default 32, meaning the register-file depth; index 0 is hard-wired zero.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 id_valid  in  1  the ID stage holds a real instruction.
REQ-005 id_rs, id_rt  in  5 each  ID source register indices.
REQ-006 id_rs_used, id_rt_used  in  1 each  the corresponding source is read as an ALU operand.
REQ-007 id_st_data  in  1  rt is the store-data operand and is not an ALU operand.
REQ-008 id_rd  in  5  ID destination index.
REQ-009 id_regwrite, id_load  in  1 each  ID writes id_rd; ID is a load.
REQ-010 ex_fail  in  1  branch in EX resolved as mispredicted; the younger instructions are wrong-path.
REQ-011 ALUsrcA, ALUsrcB, MemWrSrc  out  2 each  EX operand selects: 00 register, 01 Ex_OUT, 10 Mem_OUT; 11 is never driven.
REQ-012 stall  out  1  hold PC and IF/ID this cycle.
REQ-013 flush  out  1  squash IF/ID this cycle.

Function
REQ-014 The block SHALL keep three internal stage records, EX, MEM and WB; each record holds {valid, rd, regwrite, load}.
REQ-015 Each cycle, MEM SHALL take the value of EX and WB SHALL take the value of MEM.
REQ-016 EX SHALL take the ID instruction when id_valid && !stall && !flush; otherwise EX SHALL take a bubble (valid=0).
REQ-017 A record SHALL match source s only when valid && regwrite && rd==s && s!=0.
REQ-018 Operand select (FWD_EN defined): a match in the current EX record gives 01 and takes priority; otherwise a match in the current MEM record gives 10; otherwise 00.
REQ-019 The operand selects SHALL be computed at ID and registered into ALUsrcA/ALUsrcB/MemWrSrc on the edge that moves the instruction into EX.
REQ-020 ALUsrcA SHALL be computed from id_rs and ALUsrcB from id_rt when id_rt_used.
REQ-021 MemWrSrc SHALL be computed from id_rt when id_st_data.
REQ-022 An unused source SHALL give select 00.
REQ-023 On a bubble, all three selects SHALL be registered as 00.
REQ-024 Load-use: stall=1 when id_valid and a used source or store-data source matches an EX record with load=1.
REQ-025 The load-use stall SHALL last exactly one cycle; after it the load sits in MEM and the select is 10.
REQ-026 The WB stage is never forwarded; the register file is write-before-read.
REQ-027 flush SHALL equal ex_fail, combinationally.
REQ-028 flush SHALL override stall: when ex_fail=1, stall=0 and a bubble enters EX.
REQ-029 stall SHALL be combinational from the ID inputs and the records, with no dependency on ex_fail other than REQ-028.
REQ-030 Back-to-back loads and repeated hazards SHALL be handled independently each cycle, with no lockout.

Reset
REQ-031 When rst=1 at a clock edge, all records SHALL become invalid and ALUsrcA, ALUsrcB and MemWrSrc SHALL become 00.
REQ-032 stall and flush SHALL be 0 while rst=1.
REQ-033 A reset that arrives mid-stall SHALL cancel the stall; no stale forward SHALL survive the reset.

Configuration
REQ-034 Macro FWD_HAZARD_FWD_EN SHALL control forwarding.
REQ-035 With FWD_HAZARD_FWD_EN defined, the block SHALL behave as REQ-018..REQ-025.
REQ-036 With FWD_HAZARD_FWD_EN undefined, all selects SHALL be fixed at 00.
REQ-037 With FWD_HAZARD_FWD_EN undefined, stall=1 whenever any used source matches EX or MEM, loads or not; this gives a maximum stall of 2 cycles per hazard.

Structure
REQ-038 A shared package SHALL hold the select encodings SEL_REG=2'b00, SEL_EXOUT=2'b01, SEL_MEMOUT=2'b10.
REQ-039 The shared package SHALL hold the stage-record typedef.
REQ-040 A sub-module fwd_sel SHALL be instantiated three times (A, B, store data); it is combinational: a source index and the two records in, a 2-bit select out.

Verification
REQ-041 add r3 then add r4,r3,r5 back-to-back -> ALUsrcA=01 in the second instruction's EX cycle; stall stays 0.
REQ-042 add r3, nop, sub r6,r1,r3 -> ALUsrcB=10 for the sub; no stall.
REQ-043 lw r2 then add r7,r2,r2 -> stall=1 for exactly 1 cycle, bubble selects 00, then ALUsrcA=ALUsrcB=10.
REQ-044 add r2, add r2, sw r2 -> MemWrSrc=01 (youngest producer wins); write to r0 followed by a read of r0 -> select 00.
REQ-045 A load-use stall coinciding with ex_fail=1 -> flush=1, stall=0, bubble in EX.
REQ-046 With FWD_HAZARD_FWD_EN undefined, add r3 then add r4,r3,r5 -> stall 2 cycles, selects 00.
REQ-047 rst asserted during a stall -> on the next cycle stall=0 and all selects are 00.
